// File: rtl/sync_fifo_rd_stream.sv
// Purpose: drains a first-word-fall-through FIFO read port into a registered valid/ready stream via a 2-entry skid buffer.
// Latency: FIFO word popped in cycle N appears on data_o/valid_o in cycle N+1; sustains 1 word/cycle.
// Backpressure: ready_i low fills the skid slot, then pops stop; rd_en_o never depends on ready_i.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   rd_en_o             FIFO pop request (combinational from state, rempty_i, flush_i, rst_i)
//   rdata_i, rempty_i   FIFO head word and empty flag
//   valid_o, data_o     registered stream output, ready_i is the consumer handshake
//   flush_i             drop every buffered word (FIFO itself untouched)
//   level_o             words held here (0..2)
//   count_o             accepted stream words, wraps modulo 2^CNT_WIDTH
module sync_fifo_rd_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  rd_en_o,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic                  rempty_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  ready_i,
    input  logic                  flush_i,
    output logic [1:0]            level_o,
    output logic [CNT_WIDTH-1:0]  count_o
);

    // Encoding doubles as the buffered-word count driven on level_o.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  pop;
    logic                  accept;

    // Pop only while a free slot is guaranteed regardless of this cycle's
    // handshake; this keeps ready_i out of the rd_en_o cone.
    assign pop     = !rst_i && !rempty_i && !flush_i && (state_q != ST_TWO);
    assign valid_o = (state_q != ST_EMPTY);
    assign accept  = valid_o && ready_i;

    assign rd_en_o = pop;
    assign data_o  = out_q;
    assign level_o = state_q;
    assign count_o = cnt_q;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        // An accept during a flush still counts as delivered.
        cnt_d   = cnt_q + {{(CNT_WIDTH-1){1'b0}}, accept};

        if (flush_i) begin
            // Buffered words are dropped; out_q keeps its value so data_o
            // does not change, only valid_o falls.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (pop) begin
                        state_d = ST_ONE;
                        out_d   = rdata_i;
                    end
                end
                ST_ONE: begin
                    if (pop && accept) begin
                        out_d = rdata_i;
                    end else if (pop) begin
                        state_d = ST_TWO;
                        skid_d  = rdata_i;
                    end else if (accept) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // No pop is possible here, so the skid word moves up alone.
                    if (accept) begin
                        state_d = ST_ONE;
                        out_d   = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sync_fifo_rd_stream.sv
// Purpose: self-checking bench for sync_fifo_rd_stream against a queue-based FIFO and buffer model.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: ready_i patterns are directed per scenario or random at 50%.
module tb_sync_fifo_rd_stream;

    localparam int DW = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          rempty_i;
    logic          ready_i;
    logic          flush_i;
    logic [DW-1:0] rdata_i;

    logic          rd_en_o,  valid_o;
    logic [DW-1:0] data_o;
    logic [1:0]    level_o;
    logic [15:0]   count_o;

    logic          rd_en4, valid4;
    logic [DW-1:0] data4;
    logic [1:0]    level4;
    logic [3:0]    count4;

    sync_fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .rd_en_o(rd_en_o), .rdata_i(rdata_i),
        .rempty_i(rempty_i), .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i),
        .flush_i(flush_i), .level_o(level_o), .count_o(count_o)
    );

    sync_fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut4 (
        .clk_i(clk_i), .rst_i(rst_i), .rd_en_o(rd_en4), .rdata_i(rdata_i),
        .rempty_i(rempty_i), .valid_o(valid4), .data_o(data4), .ready_i(ready_i),
        .flush_i(flush_i), .level_o(level4), .count_o(count4)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    // Environment and reference model: the FIFO contents, the words held by
    // the block (head is the one on data_o), the last presented word and
    // the number of accepted words.
    logic [DW-1:0] fifo[$];
    logic [DW-1:0] mbuf[$];
    logic [DW-1:0] acc_log[$];
    logic [DW-1:0] mdata = '0;
    int unsigned   mcnt  = 0;

    logic          obs_rd_en, obs_valid, obs_empty, obs_rd_en4, obs_valid4;
    logic [DW-1:0] obs_data, obs_data4;
    logic [1:0]    obs_level, obs_level4;
    logic [15:0]   obs_cnt;
    logic [3:0]    obs_cnt4;
    logic          exp_rd_en, exp_valid, exp_acc;
    logic [DW-1:0] exp_data;
    logic [1:0]    exp_level;
    logic [15:0]   exp_cnt;
    logic [3:0]    exp_cnt4;

    // One clock cycle: apply inputs, sample outputs and model expectations
    // on the falling edge, then advance the model across the rising edge.
    task automatic drive(input logic rst, input logic rdy, input logic fl);
        rst_i    = rst;
        ready_i  = rdy;
        flush_i  = fl;
        rempty_i = (fifo.size() == 0);
        if (fifo.size() != 0) rdata_i = fifo[0];
        else                  rdata_i = 16'($urandom);
        #4;
        exp_rd_en = !rst && (fifo.size() != 0) && !fl && (mbuf.size() < 2);
        exp_valid = (mbuf.size() != 0);
        exp_acc   = exp_valid && rdy;
        exp_data  = mdata;
        exp_level = 2'(mbuf.size());
        exp_cnt   = 16'(mcnt);
        exp_cnt4  = 4'(mcnt);
        obs_rd_en = rd_en_o;  obs_valid = valid_o;  obs_data = data_o;
        obs_level = level_o;  obs_cnt = count_o;    obs_empty = rempty_i;
        obs_rd_en4 = rd_en4;  obs_valid4 = valid4;  obs_data4 = data4;
        obs_level4 = level4;  obs_cnt4 = count4;
        if (!rst && obs_valid && rdy) acc_log.push_back(obs_data);
        @(posedge clk_i);
        #1;
        if (rst) begin
            mbuf.delete();
            mdata = '0;
            mcnt  = 0;
        end else begin
            if (exp_acc) begin
                mbuf.delete(0);
                mcnt++;
            end
            if (fl) mbuf.delete();
            else if (exp_rd_en) mbuf.push_back(fifo.pop_front());
            if (mbuf.size() != 0) mdata = mbuf[0];
        end
    endtask

    task automatic test_reset();
        fifo.delete();
        fifo.push_back(16'h5A5A);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        n_vec++;
        if (obs_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en got %0b want 0", obs_rd_en); end
        drive(1'b0, 1'b0, 1'b0);
        n_vec++;
        if (obs_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", obs_valid); end
        n_vec++;
        if (obs_level !== 2'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", obs_level); end
        n_vec++;
        if (obs_cnt !== 16'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", obs_cnt); end
        n_vec++;
        if (obs_data !== 16'h0000) begin n_err++; $display("FAIL reset_data got %h want 0000", obs_data); end
        n_vec++;
        if (obs_rd_en !== 1'b1) begin n_err++; $display("FAIL reset_release_pop got %0b want 1", obs_rd_en); end
    endtask

    task automatic test_stream();
        fifo.delete();
        for (int i = 1; i <= 4; i++) fifo.push_back(16'(i));
        drive(1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 7; c++) begin
            drive(1'b0, 1'b1, 1'b0);
            n_vec++;
            if (obs_rd_en !== (c < 4)) begin
                n_err++; $display("FAIL stream_rd_en c=%0d got %0b want %0b", c, obs_rd_en, (c < 4));
            end
            n_vec++;
            if (obs_valid !== (c >= 1 && c <= 4)) begin
                n_err++; $display("FAIL stream_valid c=%0d got %0b want %0b", c, obs_valid, (c >= 1 && c <= 4));
            end
            if (c >= 1 && c <= 4) begin
                n_vec++;
                if (obs_data !== 16'(c)) begin
                    n_err++; $display("FAIL stream_data c=%0d got %h want %h", c, obs_data, 16'(c));
                end
            end
        end
        n_vec++;
        if (obs_cnt !== 16'd4) begin n_err++; $display("FAIL stream_count got %0d want 4", obs_cnt); end
        n_vec++;
        if (obs_level !== 2'd0) begin n_err++; $display("FAIL stream_level got %0d want 0", obs_level); end
    endtask

    task automatic test_backpressure();
        int pops;
        fifo.delete();
        for (int i = 0; i < 4; i++) fifo.push_back(16'h00A0 + 16'(i));
        drive(1'b1, 1'b0, 1'b0);
        pops = 0;
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 1'b0, 1'b0);
            pops += int'(obs_rd_en);
            if (c >= 1) begin
                n_vec++;
                if (obs_data !== 16'h00A0) begin
                    n_err++; $display("FAIL bp_hold_data c=%0d got %h want 00a0", c, obs_data);
                end
            end
        end
        n_vec++;
        if (pops != 2) begin n_err++; $display("FAIL bp_pops got %0d want 2", pops); end
        n_vec++;
        if (obs_level !== 2'd2) begin n_err++; $display("FAIL bp_level got %0d want 2", obs_level); end
        n_vec++;
        if (obs_rd_en !== 1'b0) begin n_err++; $display("FAIL bp_rd_en got %0b want 0", obs_rd_en); end
        for (int r = 0; r < 6; r++) begin
            drive(1'b0, 1'b1, 1'b0);
            n_vec++;
            if (obs_valid !== (r < 4)) begin
                n_err++; $display("FAIL bp_drain_valid r=%0d got %0b want %0b", r, obs_valid, (r < 4));
            end
            if (r < 4) begin
                n_vec++;
                if (obs_data !== 16'h00A0 + 16'(r)) begin
                    n_err++; $display("FAIL bp_drain_data r=%0d got %h want %h", r, obs_data, 16'h00A0 + 16'(r));
                end
            end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] sent[$];
        int cyc;
        int k;
        int n;
        fifo.delete();
        drive(1'b1, 1'b0, 1'b0);
        acc_log.delete();
        for (int i = 0; i < 1000; i++) sent.push_back(16'($urandom));
        k   = 0;
        cyc = 0;
        while (acc_log.size() < 1000 && cyc < 20000) begin
            n = $urandom_range(0, 2);
            for (int j = 0; j < n && k < 1000; j++) begin
                fifo.push_back(sent[k]);
                k++;
            end
            drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            n_vec++;
            if ({obs_rd_en, obs_valid, obs_data, obs_level, obs_cnt} !==
                {exp_rd_en, exp_valid, exp_data, exp_level, exp_cnt}) begin
                n_err++;
                $display("FAIL rand_cycle16 cyc=%0d got rd=%0b v=%0b d=%h l=%0d c=%0d want rd=%0b v=%0b d=%h l=%0d c=%0d",
                         cyc, obs_rd_en, obs_valid, obs_data, obs_level, obs_cnt,
                         exp_rd_en, exp_valid, exp_data, exp_level, exp_cnt);
            end
            n_vec++;
            if ({obs_rd_en4, obs_valid4, obs_data4, obs_level4, obs_cnt4} !==
                {exp_rd_en, exp_valid, exp_data, exp_level, exp_cnt4}) begin
                n_err++;
                $display("FAIL rand_cycle4 cyc=%0d got rd=%0b v=%0b d=%h l=%0d c=%0d want rd=%0b v=%0b d=%h l=%0d c=%0d",
                         cyc, obs_rd_en4, obs_valid4, obs_data4, obs_level4, obs_cnt4,
                         exp_rd_en, exp_valid, exp_data, exp_level, exp_cnt4);
            end
            n_vec++;
            if (obs_rd_en && obs_empty) begin
                n_err++; $display("FAIL rand_pop_when_empty cyc=%0d got rd_en=1 want 0", cyc);
            end
            cyc++;
        end
        n_vec++;
        if (acc_log.size() != 1000) begin
            n_err++; $display("FAIL rand_delivered got %0d want 1000 (cycle budget)", acc_log.size());
        end
        for (int i = 0; i < 1000 && i < acc_log.size(); i++) begin
            n_vec++;
            if (acc_log[i] !== sent[i]) begin
                n_err++; $display("FAIL rand_order idx=%0d got %h want %h", i, acc_log[i], sent[i]);
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        n_vec++;
        if (obs_cnt !== 16'd1000) begin n_err++; $display("FAIL rand_count got %0d want 1000", obs_cnt); end
        n_vec++;
        if (obs_cnt4 !== 4'd8) begin n_err++; $display("FAIL rand_count4 got %0d want 8", obs_cnt4); end
    endtask

    task automatic test_flush();
        fifo.delete();
        fifo.push_back(16'h1111);
        fifo.push_back(16'h2222);
        fifo.push_back(16'h3333);
        drive(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) drive(1'b0, 1'b0, 1'b0);
        n_vec++;
        if (obs_level !== 2'd2) begin n_err++; $display("FAIL flush_pre_level got %0d want 2", obs_level); end
        acc_log.delete();
        drive(1'b0, 1'b1, 1'b1);
        n_vec++;
        if ({obs_rd_en, obs_valid, obs_data} !== {1'b0, 1'b1, 16'h1111}) begin
            n_err++; $display("FAIL flush_cycle got rd=%0b v=%0b d=%h want rd=0 v=1 d=1111", obs_rd_en, obs_valid, obs_data);
        end
        drive(1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({obs_valid, obs_level} !== {1'b0, 2'd0}) begin
            n_err++; $display("FAIL flush_after got v=%0b l=%0d want v=0 l=0", obs_valid, obs_level);
        end
        n_vec++;
        if (obs_cnt !== 16'd1) begin n_err++; $display("FAIL flush_count got %0d want 1", obs_cnt); end
        n_vec++;
        if (obs_rd_en !== 1'b1) begin n_err++; $display("FAIL flush_resume_pop got %0b want 1", obs_rd_en); end
        for (int c = 0; c < 4; c++) drive(1'b0, 1'b1, 1'b0);
        n_vec++;
        if (acc_log.size() != 2) begin
            n_err++; $display("FAIL flush_delivered got %0d words want 2", acc_log.size());
        end else begin
            n_vec++;
            if ({acc_log[0], acc_log[1]} !== {16'h1111, 16'h3333}) begin
                n_err++; $display("FAIL flush_words got %h %h want 1111 3333", acc_log[0], acc_log[1]);
            end
        end
        fifo.push_back(16'h4444);
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b1, 1'b1);
            n_vec++;
            if ({obs_rd_en, obs_valid} !== 2'b00) begin
                n_err++; $display("FAIL flush_hold c=%0d got rd=%0b v=%0b want 0 0", c, obs_rd_en, obs_valid);
            end
        end
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        n_vec++;
        if ({obs_valid, obs_data} !== {1'b1, 16'h4444}) begin
            n_err++; $display("FAIL flush_release got v=%0b d=%h want v=1 d=4444", obs_valid, obs_data);
        end
    endtask

    task automatic test_count_wrap();
        int nacc;
        fifo.delete();
        for (int i = 0; i < 17; i++) fifo.push_back(16'h0C00 + 16'(i));
        drive(1'b1, 1'b0, 1'b0);
        nacc = 0;
        for (int c = 0; c < 22; c++) begin
            drive(1'b0, 1'b1, 1'b0);
            if (nacc >= 15) begin
                n_vec++;
                if (obs_cnt4 !== 4'(nacc)) begin
                    n_err++; $display("FAIL wrap_count4 after=%0d got %0d want %0d", nacc, obs_cnt4, nacc % 16);
                end
                n_vec++;
                if (obs_cnt !== 16'(nacc)) begin
                    n_err++; $display("FAIL wrap_count16 after=%0d got %0d want %0d", nacc, obs_cnt, nacc);
                end
            end
            if (obs_valid) nacc++;
        end
        n_vec++;
        if (nacc != 17) begin n_err++; $display("FAIL wrap_accepts got %0d want 17", nacc); end
    endtask

    task automatic test_reset_mid();
        fifo.delete();
        for (int i = 0; i < 6; i++) fifo.push_back(16'h00B0 + 16'(i));
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        n_vec++;
        if ({obs_level, obs_rd_en} !== {2'd2, 1'b0}) begin
            n_err++; $display("FAIL rmid_in_reset got l=%0d rd=%0b want l=2 rd=0", obs_level, obs_rd_en);
        end
        n_vec++;
        if (obs_cnt !== 16'd1) begin n_err++; $display("FAIL rmid_pre_count got %0d want 1", obs_cnt); end
        drive(1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({obs_valid, obs_level, obs_cnt} !== {1'b0, 2'd0, 16'd0}) begin
            n_err++; $display("FAIL rmid_after got v=%0b l=%0d c=%0d want v=0 l=0 c=0", obs_valid, obs_level, obs_cnt);
        end
        n_vec++;
        if (obs_rd_en !== 1'b1) begin n_err++; $display("FAIL rmid_resume got %0b want 1", obs_rd_en); end
        drive(1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({obs_valid, obs_level, obs_data} !== {1'b1, 2'd1, 16'h00B3}) begin
            n_err++; $display("FAIL rmid_next got v=%0b l=%0d d=%h want v=1 l=1 d=00b3", obs_valid, obs_level, obs_data);
        end
    endtask

    initial begin
        rst_i    = 1'b1;
        ready_i  = 1'b0;
        flush_i  = 1'b0;
        rempty_i = 1'b1;
        rdata_i  = '0;
        @(posedge clk_i);
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_random();
        test_flush();
        test_count_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
